// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and the serial-unit state type.
package alu_pkg;
  localparam int ALU_WIDTH = 8;
  localparam int SLICE_W   = 2;
  localparam int NSLICE    = ALU_WIDTH / SLICE_W;
  localparam int KW        = $clog2(NSLICE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub2b_bw.sv
// Combinational 2-bit borrow-ripple subtract slice: d = a - b - bin.
module sub2b_bw
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);
  logic [SLICE_W:0] br;

  assign br[0] = bin;

  for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
    assign d[gi]    = a[gi] ^ b[gi] ^ br[gi];
    assign br[gi+1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & br[gi]);
  end

  assign bout = br[SLICE_W];
endmodule

// File: rtl/sub8b_ser.sv
// Digit-serial 8-bit subtractor, 2 bits per clock through one shared slice.
// Define SUB8B_FLAGS_EN to build the registered zero/ovf flags.
module sub8b_ser
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ALU_WIDTH-1:0] inA,
  input  logic [ALU_WIDTH-1:0] inB,
  input  logic                 bin,
  output logic                 ready,
  output logic                 valid,
  output logic [ALU_WIDTH-1:0] diff,
  output logic                 bout,
  output logic                 zero,
  output logic                 ovf
);
  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [ALU_WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic                 borrow_q, borrow_d;
  logic [SLICE_W-1:0]   slice_d;
  logic                 slice_bout;
  logic                 accept;
  logic                 last_slice;

  assign accept     = start && (state_q != RUN);
  assign last_slice = (state_q == RUN) && (k_q == KW'(NSLICE - 1));

  sub2b_bw u_slice (
    .a    (a_q[k_q*SLICE_W +: SLICE_W]),
    .b    (b_q[k_q*SLICE_W +: SLICE_W]),
    .bin  (borrow_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q != RUN);
    valid = (state_q == DONE);
  end

  // A start in RUN never reaches here because accept excludes RUN.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    k_d      = k_q;
    if (accept) begin
      a_d      = inA;
      b_d      = inB;
      borrow_d = bin;
      diff_d   = '0;
      k_d      = '0;
    end else if (state_q == RUN) begin
      diff_d[k_q*SLICE_W +: SLICE_W] = slice_d;
      borrow_d = slice_bout;
      k_d      = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      k_q      <= k_d;
    end
  end

  assign diff = diff_q;
  assign bout = borrow_q;

`ifdef SUB8B_FLAGS_EN
  logic zero_q, ovf_q;

  // Flags are taken from the completed difference on the final slice edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_slice) begin
      zero_q <= (diff_d == '0);
      ovf_q  <= (a_q[ALU_WIDTH-1] != b_q[ALU_WIDTH-1]) &&
                (diff_d[ALU_WIDTH-1] != a_q[ALU_WIDTH-1]);
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif
endmodule
